// File: rtl/clock_gen_multi.sv
// clock_gen_multi: NUM_CH independent divided clocks from one fabric clock.
//   Each channel counts 0..N and toggles its output on the wrap, so the
//   output period is 2*(N+1) fabric cycles at 50% duty. Divisor changes are
//   staged in a pending register and applied only at the end of a full
//   period (the 1->0 wrap), so no phase is ever shortened or stretched.
//
// Optional feature macro: CLKGEN_GATE_EN (adds i_gate run-enable per channel).
//
// Ports:
//   i_clk       fabric clock, the only clock in the block
//   i_rst       synchronous reset, active low
//   i_gate      (CLKGEN_GATE_EN only) per-channel run enable, active high
//   i_sync      phase-align pulse, restarts every channel at counter 0 / low
//   i_ld        divisor load strobe
//   i_ld_ch     channel targeted by i_ld (values >= NUM_CH are ignored)
//   i_ld_div    new divisor N
//   o_clk_out   divided clocks, registered
//   o_rise_stb  one-cycle strobe in the first cycle o_clk_out[i] is high
//   o_fall_stb  one-cycle strobe in the first cycle o_clk_out[i] is low
//   o_pend      divisor change pending on channel i

// Per-channel divider. Holds active and pending divisor, counter, output
// level and the two edge strobes.
module clock_gen_multi_ch #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sync,
  input  logic             i_gate,
  input  logic             i_ld,
  input  logic [CNT_W-1:0] i_ld_div,
  output logic             o_clk,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_pend
);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_pdiv;
  logic             r_pend;
  logic             r_clk;
  logic             r_rise;
  logic             r_fall;
  logic             w_wrap;
  logic             w_stop;

  assign w_wrap = (r_cnt == r_div);
  // A gated channel only parks once it is low; a high phase always finishes
  // first, so the output never stops high and never produces a runt pulse.
  assign w_stop = ~i_gate & ~r_clk;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cnt  <= '0;
      r_div  <= CNT_W'(DEF_DIV);
      r_pdiv <= '0;
      r_pend <= 1'b0;
      r_clk  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (i_sync) begin
      // Restart low; a same-cycle load bypasses the pending stage.
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= r_clk;
      r_pend <= 1'b0;
      if (i_ld)        r_div <= i_ld_div;
      else if (r_pend) r_div <= r_pdiv;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (i_ld) begin
        r_pdiv <= i_ld_div;
        r_pend <= 1'b1;
      end
      if (w_stop) begin
        r_cnt <= '0;
        // Parked: nothing is running, so a pending divisor can go live now.
        if (r_pend) begin
          r_div  <= r_pdiv;
          r_pend <= i_ld;
        end
      end else if (w_wrap) begin
        r_cnt  <= '0;
        r_clk  <= ~r_clk;
        r_rise <= ~r_clk;
        r_fall <= r_clk;
        // End of a full period: apply the value that was pending before this
        // edge; a load arriving in the same cycle stays pending.
        if (r_clk && r_pend) begin
          r_div  <= r_pdiv;
          r_pend <= i_ld;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_clk  = r_clk;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
  assign o_pend = r_pend;
endmodule

module clock_gen_multi #(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 4,
  parameter int SEL_W   = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
`ifdef CLKGEN_GATE_EN
  input  logic [NUM_CH-1:0] i_gate,
`endif
  input  logic              i_sync,
  input  logic              i_ld,
  input  logic [SEL_W-1:0]  i_ld_ch,
  input  logic [CNT_W-1:0]  i_ld_div,
  output logic [NUM_CH-1:0] o_clk_out,
  output logic [NUM_CH-1:0] o_rise_stb,
  output logic [NUM_CH-1:0] o_fall_stb,
  output logic [NUM_CH-1:0] o_pend
);
  logic [NUM_CH-1:0] w_gate;
  logic [NUM_CH-1:0] w_hit;

`ifdef CLKGEN_GATE_EN
  assign w_gate = i_gate;
`else
  assign w_gate = '1;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // Only indices below NUM_CH are decoded, so out-of-range selects hit
    // no channel at all.
    assign w_hit[g] = i_ld && (i_ld_ch == SEL_W'(g));

    clock_gen_multi_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_sync   (i_sync),
      .i_gate   (w_gate[g]),
      .i_ld     (w_hit[g]),
      .i_ld_div (i_ld_div),
      .o_clk    (o_clk_out[g]),
      .o_rise   (o_rise_stb[g]),
      .o_fall   (o_fall_stb[g]),
      .o_pend   (o_pend[g])
    );
  end
endmodule
